// File: rtl/matrix_block_multiplier_if.sv
// Start/busy/done handshake and flattened 4x4 operand/result bus for the block multiplier.
interface matrix_block_multiplier_if #(
    parameter int unsigned W = 32
);
    localparam int unsigned FLAT_W = 16 * W;

    logic              start;
    logic [FLAT_W-1:0] a_flat;
    logic [FLAT_W-1:0] b_flat;
    logic [FLAT_W-1:0] c_flat;
    logic              busy;
    logic              done;

    modport master (
        output start, a_flat, b_flat,
        input  c_flat, busy, done
    );

    modport slave (
        input  start, a_flat, b_flat,
        output c_flat, busy, done
    );
endinterface

// File: rtl/matrix_block_multiplier.sv
// Sequential 4x4 matrix multiplier, C = A x B mod 2^W, built from eight 2x2 block
// products accumulated one per clock into the four 2x2 blocks of C.
module matrix_block_multiplier #(
    parameter int unsigned W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    matrix_block_multiplier_if.slave  mbus
);
    localparam int unsigned NEL    = 16;
    localparam int unsigned FLAT_W = NEL * W;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        FIN
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          step_q, step_d;
    logic [W-1:0]        a_q   [NEL];
    logic [W-1:0]        a_d   [NEL];
    logic [W-1:0]        b_q   [NEL];
    logic [W-1:0]        b_d   [NEL];
    logic [W-1:0]        acc_q [NEL];
    logic [W-1:0]        acc_d [NEL];
    logic [FLAT_W-1:0]   c_q, c_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [W-1:0]        dot;

    // Element (r,c) lives at index {r[1:0], c[1:0]}; block step s picks i=s[2], j=s[1], k=s[0].
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = done_q;
        dot     = '0;

        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (mbus.start) begin
                    for (int e = 0; e < NEL; e++) begin
                        a_d[e]   = mbus.a_flat[e*W +: W];
                        b_d[e]   = mbus.b_flat[e*W +: W];
                        acc_d[e] = '0;
                    end
                    step_d  = 3'd0;
                    busy_d  = 1'b1;
                    state_d = MUL;
                end
            end

            MUL: begin
                for (int r = 0; r < 2; r++) begin
                    for (int c = 0; c < 2; c++) begin
                        dot = a_q[{step_q[2], 1'(r), step_q[0], 1'b0}]
                                * b_q[{step_q[0], 1'b0, step_q[1], 1'(c)}]
                            + a_q[{step_q[2], 1'(r), step_q[0], 1'b1}]
                                * b_q[{step_q[0], 1'b1, step_q[1], 1'(c)}];
                        acc_d[{step_q[2], 1'(r), step_q[1], 1'(c)}] =
                            acc_q[{step_q[2], 1'(r), step_q[1], 1'(c)}] + dot;
                    end
                end
                if (step_q == 3'd7) begin
                    state_d = FIN;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end

            FIN: begin
                for (int e = 0; e < NEL; e++) begin
                    c_d[e*W +: W] = acc_q[e];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            for (int e = 0; e < NEL; e++) begin
                a_q[e]   <= '0;
                b_q[e]   <= '0;
                acc_q[e] <= '0;
            end
            c_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mbus.c_flat = c_q;
    assign mbus.busy   = busy_q;
    assign mbus.done   = done_q;
endmodule

// File: tb/tb_matrix_block_multiplier.sv
// Scoreboard bench for matrix_block_multiplier: driver queues reference products, a
// negedge monitor checks every done pulse against the queue.
module tb_matrix_block_multiplier;
    localparam int unsigned W = 32;
    localparam int unsigned N = 16 * W;
    typedef logic [N-1:0] mat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_block_multiplier_if #(.W(W)) bus ();

    matrix_block_multiplier #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mbus  (bus)
    );

    mat_t exp_q[$];
    mat_t last_c   = '0;
    int   n_vec    = 0;
    int   n_err    = 0;
    logic prev_done = 1'b0;

    function automatic mat_t ref_mul(input mat_t a, input mat_t b);
        mat_t         c;
        logic [W-1:0] s;
        logic [W-1:0] x;
        logic [W-1:0] y;
        c = '0;
        for (int r = 0; r < 4; r++) begin
            for (int col = 0; col < 4; col++) begin
                s = '0;
                for (int k = 0; k < 4; k++) begin
                    x = a[(r*4+k)*W +: W];
                    y = b[(k*4+col)*W +: W];
                    s = s + x * y;
                end
                c[(r*4+col)*W +: W] = s;
            end
        end
        return c;
    endfunction

    function automatic mat_t fill(input logic [W-1:0] v);
        mat_t m;
        for (int e = 0; e < 16; e++) m[e*W +: W] = v;
        return m;
    endfunction

    function automatic mat_t set_el(input mat_t m, input int r, input int c, input logic [W-1:0] v);
        mat_t o;
        o = m;
        o[(r*4+c)*W +: W] = v;
        return o;
    endfunction

    function automatic mat_t rnd_mat();
        mat_t         m;
        logic [W-1:0] mask;
        mask = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        for (int e = 0; e < 16; e++) m[e*W +: W] = $urandom() & mask;
        return m;
    endfunction

    task automatic check(input string name, input mat_t act, input mat_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued result and last one cycle.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL done_unexpected: done=1 with no pending multiply");
            end else begin
                check("c_flat", bus.c_flat, exp_q.pop_front());
            end
            check("done_width", N'(prev_done), N'(1'b0));
        end
        prev_done = rst_n ? bus.done : 1'b0;
    end

    // Caller is at a negedge; start is presented for exactly one rising edge.
    task automatic issue(input mat_t a, input mat_t b);
        bus.start  = 1'b1;
        bus.a_flat = a;
        bus.b_flat = b;
        exp_q.push_back(ref_mul(a, b));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run(input mat_t a, input mat_t b, input bit disturb);
        int   cnt;
        mat_t e;
        cnt = 0;
        e   = ref_mul(a, b);
        issue(a, b);
        while (bus.busy && cnt < 30) begin
            check("c_hold", bus.c_flat, last_c);
            if (disturb && cnt == 1) begin
                bus.start  = 1'b1;
                bus.a_flat = rnd_mat();
            end
            if (disturb && cnt == 2) begin
                bus.start  = 1'b0;
                bus.a_flat = rnd_mat();
                bus.b_flat = rnd_mat();
            end
            cnt++;
            @(negedge clk);
        end
        check("busy_cycles", N'(cnt), N'(9));
        check("done_pulse", N'(bus.done), N'(1'b1));
        last_c = e;
    endtask

    initial begin
        mat_t a;
        mat_t b;
        int   gap;

        bus.start  = 1'b0;
        bus.a_flat = '0;
        bus.b_flat = '0;
        @(negedge clk);
        check("rst_c_flat", bus.c_flat, '0);
        check("rst_busy", N'(bus.busy), N'(1'b0));
        check("rst_done", N'(bus.done), N'(1'b0));
        rst_n = 1'b1;
        @(negedge clk);

        // Identity times sequential B
        a = '0;
        b = '0;
        for (int r = 0; r < 4; r++) begin
            a = set_el(a, r, r, 32'd1);
            for (int c = 0; c < 4; c++) b = set_el(b, r, c, 32'(r*4 + c));
        end
        run(a, b, 1'b0);
        check("identity_is_b", bus.c_flat, b);

        // All-2 x all-3, then back-to-back all-1 x all-1
        run(fill(32'd2), fill(32'd3), 1'b0);
        check("all24", bus.c_flat, fill(32'h18));
        run(fill(32'd1), fill(32'd1), 1'b0);
        check("all4", bus.c_flat, fill(32'd4));

        // Wrap and signed cases
        run(set_el('0, 0, 0, 32'h0001_0000), set_el('0, 0, 0, 32'h0001_0000), 1'b0);
        check("wrap_zero", bus.c_flat, '0);
        run(set_el('0, 1, 1, 32'hFFFF_FFFF), set_el('0, 1, 2, 32'd5), 1'b0);
        check("signed_neg5", bus.c_flat, set_el('0, 1, 2, 32'hFFFF_FFFB));

        // Start pulse and operand changes mid-run are ignored
        run(rnd_mat(), rnd_mat(), 1'b1);

        // Reset mid-run aborts with no done pulse
        @(negedge clk);
        issue(rnd_mat(), rnd_mat());
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        last_c = '0;
        #1;
        check("abort_c_flat", bus.c_flat, '0);
        check("abort_busy", N'(bus.busy), N'(1'b0));
        check("abort_done", N'(bus.done), N'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a = rnd_mat();
        b = rnd_mat();
        run(a, b, 1'b0);
        check("post_reset", bus.c_flat, ref_mul(a, b));

        // Random operands with random idle gaps (0 keeps it back-to-back)
        for (int t = 0; t < 20; t++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            run(rnd_mat(), rnd_mat(), ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", N'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
